mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: per-master byte bus between N_MASTERS bus masters and the arbiter
// Signals: m_req/m_wr/m_lock request, write strobe and ownership hold (one bit per master),
//   m_a/m_dout packed per-master byte address (32b) and write data (8b),
//   m_gnt current owner one-hot, m_rvalid read-return one-hot, m_rdata shared read data.
// Modports: master (bus masters drive requests), slave (arbiter drives grants and read data).
interface mem_bus_arbiter_if #(
    parameter int N_MASTERS = 2
);
    logic [N_MASTERS-1:0]    m_req;
    logic [N_MASTERS-1:0]    m_wr;
    logic [N_MASTERS-1:0]    m_lock;
    logic [N_MASTERS*32-1:0] m_a;
    logic [N_MASTERS*8-1:0]  m_dout;
    logic [N_MASTERS-1:0]    m_gnt;
    logic [N_MASTERS-1:0]    m_rvalid;
    logic [7:0]              m_rdata;

    modport master (
        output m_req, m_wr, m_lock, m_a, m_dout,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_wr, m_lock, m_a, m_dout,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port and one IO port among N_MASTERS byte-bus masters
// Ports: clk_in, rst_n_in (asynchronous active-low), dbg_active (forces ownership to master 0),
//   bus (slave modport: per-master req/wr/lock/addr/wdata in, gnt/rvalid/rdata out),
//   ram_en/ram_wr/ram_a/ram_dout/ram_din synchronous RAM port with one-cycle read latency,
//   io_en/io_wr/io_sel/io_dout/io_din/io_full peripheral port; io_full stalls IO writes.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//   left undefined, arbitration is fixed priority with the lowest requesting index winning.
module mem_bus_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      dbg_active,
    mem_bus_arbiter_if.slave          bus,
    output logic                      ram_en,
    output logic                      ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]                ram_dout,
    input  logic [7:0]                ram_din,
    output logic                      io_en,
    output logic                      io_wr,
    output logic [2:0]                io_sel,
    output logic [7:0]                io_dout,
    input  logic [7:0]                io_din,
    input  logic                      io_full
);
    localparam int IW = $clog2(N_MASTERS);

    logic [IW-1:0]           owner_idx, rd_idx, pick_idx;
    logic                    owner_vld, rd_vld, rd_io, pick_vld;
    logic                    cur_req, cur_wr, cur_lock, cur_io, stall, issue, keep;
    logic [RAM_ADDR_WIDTH:0] cur_a;
    logic [7:0]              cur_dout;

    assign cur_req  = bus.m_req[owner_idx];
    assign cur_wr   = bus.m_wr[owner_idx];
    assign cur_lock = bus.m_lock[owner_idx];
    // only the decode bit pair and the RAM offset of the owner's address matter
    assign cur_a    = bus.m_a[int'(owner_idx)*32 +: RAM_ADDR_WIDTH+1];
    assign cur_dout = bus.m_dout[int'(owner_idx)*8 +: 8];
    assign cur_io   = cur_a[RAM_ADDR_WIDTH -: 2] == 2'b11;
    assign stall    = cur_io & cur_wr & io_full;
    assign issue    = owner_vld & cur_req & ~stall;
    // a stalled owner must not lose the bus before its write lands
    assign keep     = owner_vld & cur_req & (cur_lock | stall);

    assign ram_en   = issue & ~cur_io;
    assign ram_wr   = ram_en & cur_wr;
    assign ram_a    = cur_a[RAM_ADDR_WIDTH-1:0];
    assign ram_dout = cur_dout;
    assign io_en    = issue & cur_io;
    assign io_wr    = io_en & cur_wr;
    assign io_sel   = cur_a[2:0];
    assign io_dout  = cur_dout;

    assign bus.m_gnt    = owner_vld ? N_MASTERS'(1) << owner_idx : '0;
    assign bus.m_rvalid = rd_vld ? N_MASTERS'(1) << rd_idx : '0;
    // the returning read's region was latched at issue; the live decode may belong to a new access
    assign bus.m_rdata  = rd_vld ? (rd_io ? io_din : ram_din) : '0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    // scan downward so the candidate closest after the pointer wins
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_MASTERS-1; k >= 0; k--)
            if (bus.m_req[(int'(rr_ptr) + k) % N_MASTERS]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(rr_ptr) + k) % N_MASTERS);
            end
    end
`else
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_MASTERS-1; k >= 0; k--)
            if (bus.m_req[k]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(k);
            end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            owner_vld <= 1'b0;
            owner_idx <= '0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            rd_io     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            rd_vld <= issue & ~cur_wr;
            rd_idx <= owner_idx;
            rd_io  <= cur_io;
            if (dbg_active) begin
                owner_vld <= 1'b1;
                owner_idx <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                rr_ptr    <= IW'(1);
`endif
            end else if (!keep) begin
                owner_vld <= pick_vld;
                owner_idx <= pick_idx;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (pick_vld)
                    rr_ptr <= (pick_idx == IW'(N_MASTERS-1)) ? '0 : pick_idx + 1'b1;
`endif
            end
        end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench; a cycle-level reference model predicts every output per cycle
module tb_mem_bus_arbiter;
    localparam int N  = 2;
    localparam int AW = 17;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          dbg_active = 1'b0;
    logic          ram_en, ram_wr, io_en, io_wr;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_dout, io_dout;
    logic [2:0]    io_sel;
    logic [7:0]    ram_din = 8'h00;
    logic [7:0]    io_din = 8'h00;
    logic          io_full = 1'b0;

    mem_bus_arbiter_if #(.N_MASTERS(N)) bus ();

    mem_bus_arbiter #(.N_MASTERS(N), .RAM_ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .dbg_active(dbg_active), .bus(bus),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
        .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel), .io_dout(io_dout), .io_din(io_din),
        .io_full(io_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [N-1:0]  rvalid;
        logic [7:0]    rdata;
        logic          ram_en, ram_wr;
        logic [AW-1:0] ram_a;
        logic [7:0]    ram_dout;
        logic          io_en, io_wr;
        logic [2:0]    io_sel;
        logic [7:0]    io_dout;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int owner = -1;
    int ptr = 0;
    bit pend = 0;
    int pend_m = 0;
    bit pend_io = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic go(input logic rst, input logic dbg, input logic [N-1:0] req, input logic [N-1:0] wr,
                      input logic [N-1:0] lock, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [15:0] d, input logic full, input logic [7:0] rd, input logic [7:0] id);
        exp_t        e;
        logic [31:0] oa;
        bit          io, iss, stall;
        int          nxt;
        @(posedge clk_in);
        #1;
        rst_n_in = rst; dbg_active = dbg; bus.m_req = req; bus.m_wr = wr; bus.m_lock = lock;
        bus.m_a = {a1, a0}; bus.m_dout = d; io_full = full; ram_din = rd; io_din = id;
        e = '{default: '0};
        io = 0; iss = 0; stall = 0; oa = '0;
        if (!rst) begin
            owner = -1; ptr = 0; pend = 0;
        end else begin
            if (owner >= 0) e.gnt[owner] = 1'b1;
            if (pend) begin
                e.rvalid[pend_m] = 1'b1;
                e.rdata = pend_io ? id : rd;
            end
            if (owner >= 0 && req[owner]) begin
                oa = owner == 0 ? a0 : a1;
                io = ((oa >> (AW - 1)) & 32'd3) == 32'd3;
                stall = io && wr[owner] && full;
                iss = !stall;
                if (iss && io) begin
                    e.io_en = 1'b1; e.io_wr = wr[owner]; e.io_sel = oa[2:0]; e.io_dout = d[owner*8 +: 8];
                end else if (iss) begin
                    e.ram_en = 1'b1; e.ram_wr = wr[owner]; e.ram_a = oa[AW-1:0]; e.ram_dout = d[owner*8 +: 8];
                end
            end
            pend = iss && !wr[owner];
            pend_m = owner;
            pend_io = io;
            if (dbg) begin
                owner = 0; ptr = 1;
            end else if (!(owner >= 0 && req[owner] && (lock[owner] || stall))) begin
                nxt = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                for (int k = N - 1; k >= 0; k--) if (req[(ptr + k) % N]) nxt = (ptr + k) % N;
`else
                for (int k = N - 1; k >= 0; k--) if (req[k]) nxt = k;
`endif
                owner = nxt;
                if (nxt >= 0) ptr = (nxt + 1) % N;
            end
        end
        q.push_back(e);
    endtask

    initial begin
        exp_t m;
        forever begin
            @(negedge clk_in);
            if (q.size() > 0) begin
                m = q.pop_front();
                chk("gnt", 32'(bus.m_gnt), 32'(m.gnt));
                chk("rvalid", 32'(bus.m_rvalid), 32'(m.rvalid));
                chk("rdata", 32'(bus.m_rdata), 32'(m.rdata));
                chk("ram_en", 32'(ram_en), 32'(m.ram_en));
                chk("ram_wr", 32'(ram_wr), 32'(m.ram_wr));
                chk("io_en", 32'(io_en), 32'(m.io_en));
                chk("io_wr", 32'(io_wr), 32'(m.io_wr));
                if (m.ram_en) begin
                    chk("ram_a", 32'(ram_a), 32'(m.ram_a));
                    chk("ram_dout", 32'(ram_dout), 32'(m.ram_dout));
                end
                if (m.io_en) begin
                    chk("io_sel", 32'(io_sel), 32'(m.io_sel));
                    chk("io_dout", 32'(io_dout), 32'(m.io_dout));
                end
            end
        end
    end

    initial begin
        logic [31:0] ra0, ra1;
        bus.m_req = '0; bus.m_wr = '0; bus.m_lock = '0; bus.m_a = '0; bus.m_dout = '0;
        repeat (2) go(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00);
        go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00);
        // master 0 RAM read of 0x10 returning 0xA5
        repeat (3) go(1, 0, 2'b01, 2'b00, 2'b01, 32'h10, 0, 16'h0011, 0, 8'hA5, 8'h00);
        repeat (2) go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'hA5, 8'h00);
        // master 1 IO write held off by io_full for three cycles
        go(1, 0, 2'b10, 2'b10, 2'b00, 0, 32'h00030000, 16'h7700, 1, 8'h00, 8'h00);
        repeat (3) go(1, 0, 2'b10, 2'b10, 2'b00, 0, 32'h00030000, 16'h7700, 1, 8'h00, 8'h00);
        go(1, 0, 2'b10, 2'b10, 2'b00, 0, 32'h00030000, 16'h7700, 0, 8'h00, 8'h00);
        repeat (2) go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00);
        // back-to-back RAM then IO read, latency one each
        go(1, 0, 2'b01, 2'b00, 2'b01, 32'h20, 0, 0, 0, 8'h5A, 8'h3C);
        go(1, 0, 2'b01, 2'b00, 2'b01, 32'h20, 0, 0, 0, 8'h5A, 8'h3C);
        go(1, 0, 2'b01, 2'b00, 2'b01, 32'h00030004, 0, 0, 0, 8'h5A, 8'h3C);
        go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h5A, 8'h3C);
        go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h5A, 8'h3C);
        // both masters request continuously with lock low
        repeat (5) go(1, 0, 2'b11, 2'b00, 2'b00, 32'h40, 32'h80, 0, 0, 8'h12, 8'h00);
        repeat (2) go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00);
        // master 1 locked, then debug override
        repeat (3) go(1, 0, 2'b10, 2'b00, 2'b10, 0, 32'h44, 0, 0, 8'h21, 8'h00);
        repeat (2) go(1, 1, 2'b10, 2'b00, 2'b10, 0, 32'h44, 0, 0, 8'h21, 8'h00);
        repeat (2) go(1, 0, 2'b10, 2'b00, 2'b10, 0, 32'h44, 0, 0, 8'h21, 8'h00);
        repeat (2) go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 8'h00);
        // reset lands while a read return is registered
        repeat (2) go(1, 0, 2'b01, 2'b00, 2'b01, 32'h50, 0, 0, 0, 8'h99, 8'h00);
        repeat (2) go(0, 0, 2'b01, 2'b00, 2'b01, 32'h50, 0, 0, 0, 8'h99, 8'h00);
        repeat (3) go(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h99, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            ra0 = $urandom; ra1 = $urandom;
            if ($urandom_range(1, 0) == 1) ra0[AW:AW-1] = 2'b11;
            if ($urandom_range(1, 0) == 1) ra1[AW:AW-1] = 2'b11;
            go($urandom_range(199, 0) != 0, $urandom_range(15, 0) == 0, 2'($urandom), 2'($urandom),
               2'($urandom), ra0, ra1, 16'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk_in);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
